// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Two requesters share one 16-bit unsigned restoring divider. A round-robin
// arbiter picks one pending request while the divider is idle, the operands
// are captured, the quotient/remainder are computed one bit per cycle, and
// the result is announced with a single-cycle rsp_valid pulse.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   reset            synchronous, active-low reset
//   reqN_valid       requester N has a division pending (N = 0, 1)
//   reqN_dividend    requester N dividend (unsigned, DW bits)
//   reqN_divisor     requester N divisor  (unsigned, DW bits)
//   reqN_ready       requester N operands are taken this cycle
//   rsp_valid        one-cycle pulse qualifying the rsp_* fields
//   rsp_id           requester that owns the result
//   rsp_quotient     unsigned quotient (all ones on divide-by-zero)
//   rsp_remainder    unsigned remainder (dividend on divide-by-zero)
//   rsp_div_by_zero  divisor was zero
//   busy             divider is not idle
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_dividend,
    input  logic [DW-1:0] req0_divisor,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_dividend,
    input  logic [DW-1:0] req1_divisor,
    output logic          req1_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_quotient,
    output logic [DW-1:0] rsp_remainder,
    output logic          rsp_div_by_zero,
    output logic          busy
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic [DW-1:0] rem_r, rem_next_s;
    logic [DW-1:0] quo_r, quo_next_s;
    logic [DW-1:0] div_r, div_next_s;
    logic          id_r, id_next_s;
    logic          last_grant_r, last_grant_next_s;
    logic          busy_r, busy_next_s;

    logic          rsp_valid_r, rsp_valid_next_s;
    logic          rsp_id_r, rsp_id_next_s;
    logic [DW-1:0] rsp_quotient_r, rsp_quotient_next_s;
    logic [DW-1:0] rsp_remainder_r, rsp_remainder_next_s;
    logic          rsp_dbz_r, rsp_dbz_next_s;

    logic          grant_valid_s;
    logic          grant_id_s;
    logic          accept_s;
    logic [DW-1:0] sel_dividend_s;
    logic [DW-1:0] sel_divisor_s;
    logic [DW:0]   shift_rem_s;
    logic [DW:0]   trial_s;

    // Round-robin pick: on a tie the requester not granted last time wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Operand mux for the currently granted requester.
    always_comb begin
        sel_dividend_s = req0_dividend;
        sel_divisor_s  = req0_divisor;
        if (grant_id_s) begin
            sel_dividend_s = req1_dividend;
            sel_divisor_s  = req1_divisor;
        end else begin
            sel_dividend_s = req0_dividend;
            sel_divisor_s  = req0_divisor;
        end
    end

    // Ready is gated by reset so no handshake can complete while reset is held.
    assign accept_s   = reset && (state_r == IDLE) && grant_valid_s;
    assign req0_ready = accept_s && !grant_id_s;
    assign req1_ready = accept_s &&  grant_id_s;

    // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
    always_comb begin
        shift_rem_s = {rem_r, quo_r[DW-1]};
        trial_s     = shift_rem_s - {1'b0, div_r};
    end

    // Next-state, datapath and result-register update logic.
    always_comb begin
        state_next_s         = state_r;
        cnt_next_s           = cnt_r;
        rem_next_s           = rem_r;
        quo_next_s           = quo_r;
        div_next_s           = div_r;
        id_next_s            = id_r;
        last_grant_next_s    = last_grant_r;
        rsp_valid_next_s     = 1'b0;
        rsp_id_next_s        = rsp_id_r;
        rsp_quotient_next_s  = rsp_quotient_r;
        rsp_remainder_next_s = rsp_remainder_r;
        rsp_dbz_next_s       = rsp_dbz_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    last_grant_next_s = grant_id_s;
                    id_next_s         = grant_id_s;
                    div_next_s        = sel_divisor_s;
                    if (sel_divisor_s == {DW{1'b0}}) begin
                        // Divide-by-zero skips the iterations entirely.
                        state_next_s         = DONE;
                        cnt_next_s           = {CW{1'b0}};
                        rsp_valid_next_s     = 1'b1;
                        rsp_id_next_s        = grant_id_s;
                        rsp_quotient_next_s  = {DW{1'b1}};
                        rsp_remainder_next_s = sel_dividend_s;
                        rsp_dbz_next_s       = 1'b1;
                    end else begin
                        state_next_s = CALC;
                        cnt_next_s   = CW'(DW);
                        rem_next_s   = {DW{1'b0}};
                        quo_next_s   = sel_dividend_s;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                cnt_next_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                if (!trial_s[DW]) begin
                    rem_next_s = trial_s[DW-1:0];
                    quo_next_s = {quo_r[DW-2:0], 1'b1};
                end else begin
                    rem_next_s = shift_rem_s[DW-1:0];
                    quo_next_s = {quo_r[DW-2:0], 1'b0};
                end
                // Last iteration: the counter reaches zero on this edge.
                if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_next_s         = DONE;
                    rsp_valid_next_s     = 1'b1;
                    rsp_id_next_s        = id_r;
                    rsp_quotient_next_s  = quo_next_s;
                    rsp_remainder_next_s = rem_next_s;
                    rsp_dbz_next_s       = 1'b0;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        busy_next_s = (state_next_s != IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r         <= IDLE;
            cnt_r           <= {CW{1'b0}};
            rem_r           <= {DW{1'b0}};
            quo_r           <= {DW{1'b0}};
            div_r           <= {DW{1'b0}};
            id_r            <= 1'b0;
            last_grant_r    <= 1'b1;
            busy_r          <= 1'b0;
            rsp_valid_r     <= 1'b0;
            rsp_id_r        <= 1'b0;
            rsp_quotient_r  <= {DW{1'b0}};
            rsp_remainder_r <= {DW{1'b0}};
            rsp_dbz_r       <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            cnt_r           <= cnt_next_s;
            rem_r           <= rem_next_s;
            quo_r           <= quo_next_s;
            div_r           <= div_next_s;
            id_r            <= id_next_s;
            last_grant_r    <= last_grant_next_s;
            busy_r          <= busy_next_s;
            rsp_valid_r     <= rsp_valid_next_s;
            rsp_id_r        <= rsp_id_next_s;
            rsp_quotient_r  <= rsp_quotient_next_s;
            rsp_remainder_r <= rsp_remainder_next_s;
            rsp_dbz_r       <= rsp_dbz_next_s;
        end
    end

    // A reset landing on the DONE cycle suppresses that response pulse.
    assign rsp_valid       = rsp_valid_r && reset;
    assign rsp_id          = rsp_id_r;
    assign rsp_quotient    = rsp_quotient_r;
    assign rsp_remainder   = rsp_remainder_r;
    assign rsp_div_by_zero = rsp_dbz_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
// Self-checking bench for div_arbiter: a table of directed vectors, a
// reset-abort sequence, and randomized two-requester traffic checked against
// a cycle-level model built from plain division and round-robin rules.
// -----------------------------------------------------------------------------
module tb_div_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [15:0] req0_dividend;
    logic [15:0] req0_divisor;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_dividend;
    logic [15:0] req1_divisor;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_quotient;
    logic [15:0] rsp_remainder;
    logic        rsp_div_by_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit m_last   = 1'b1;   // model of the last-granted requester

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        bit          dbz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    div_arbiter #(.DW(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_dividend   (req0_dividend),
        .req0_divisor    (req0_divisor),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_dividend   (req1_dividend),
        .req1_divisor    (req1_divisor),
        .req1_ready      (req1_ready),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_quotient    (rsp_quotient),
        .rsp_remainder   (rsp_remainder),
        .rsp_div_by_zero (rsp_div_by_zero),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit id, input bit v, input logic [15:0] a, input logic [15:0] b);
        if (id) begin
            req1_valid    = v;
            req1_dividend = a;
            req1_divisor  = b;
        end else begin
            req0_valid    = v;
            req0_dividend = a;
            req0_divisor  = b;
        end
    endtask

    function automatic logic [15:0] rand_div();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'($urandom_range(2, 15));
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Single request from an idle divider; must be called just after a rising edge.
    task automatic apply_one(input bit id, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] eq, input logic [15:0] er, input bit edbz,
                             input int elat, input string tag);
        int t_acc;
        int waited;
        bit seen;
        drive(id, 1'b1, a, b);
        seen   = 1'b0;
        waited = 0;
        t_acc  = 0;
        while (!seen && waited < 20) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                seen  = 1'b1;
                t_acc = cyc;
            end else begin
                waited++;
            end
        end
        check({tag, "_accept"}, seen, 1'b1);
        check({tag, "_accept_wait"}, waited, 0);
        if (!seen) begin
            @(posedge clk); #1;
            drive(id, 1'b0, a, b);
            return;
        end
        check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 1'b0);
        m_last = id;
        @(posedge clk); #1;
        // Scramble both operand buses; the captured operation must not notice.
        drive(id, 1'b0, 16'($urandom), 16'($urandom));
        drive(!id, 1'b0, 16'($urandom), 16'($urandom));
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            else waited++;
        end
        check({tag, "_rsp_seen"}, seen, 1'b1);
        if (seen) begin
            check({tag, "_latency"}, cyc - t_acc, elat);
            check({tag, "_id"}, rsp_id, id);
            check({tag, "_quotient"}, rsp_quotient, eq);
            check({tag, "_remainder"}, rsp_remainder, er);
            check({tag, "_dbz"}, rsp_div_by_zero, edbz);
            @(negedge clk);
            check({tag, "_pulse_end"}, rsp_valid, 1'b0);
            check({tag, "_hold_q"}, rsp_quotient, eq);
            check({tag, "_idle_busy"}, busy, 1'b0);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        repeat (ncyc) begin
            @(posedge clk); #1;
        end
        reset  = 1'b1;
        m_last = 1'b1;
    endtask

    // Randomized traffic on both requesters compared cycle by cycle to a model.
    task automatic run_pair(input int nops, input bit mix);
        logic [15:0] a[2];
        logic [15:0] b[2];
        bit          v[2];
        int          busy_until = -1;
        int          rsp_cyc    = -1;
        int          nresp      = 0;
        int          ncyc       = 0;
        int          gk;
        int          lat;
        logic [15:0] ea, eb, eq, er;
        bit          edbz, eid;
        ea = 16'h0; eb = 16'h0; eq = 16'h0; er = 16'h0; edbz = 1'b0; eid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            v[k] = mix ? ($urandom_range(0, 1) == 1) : 1'b1;
            a[k] = 16'($urandom);
            b[k] = rand_div();
            drive(k[0], v[k], a[k], b[k]);
        end
        while (nresp < nops && ncyc < 3000) begin
            @(negedge clk);
            ncyc++;
            gk = -1;
            if (cyc > busy_until) begin
                if (v[0] && v[1]) gk = m_last ? 0 : 1;
                else if (v[0])    gk = 0;
                else if (v[1])    gk = 1;
                else              gk = -1;
                check("rnd_ready0", req0_ready, gk == 0);
                check("rnd_ready1", req1_ready, gk == 1);
                check("rnd_busy_idle", busy, 1'b0);
                if (gk >= 0) begin
                    eid = gk[0];
                    ea  = a[gk];
                    eb  = b[gk];
                    if (eb == 16'h0) begin
                        eq = 16'hFFFF; er = ea; edbz = 1'b1; lat = 1;
                    end else begin
                        eq = ea / eb; er = ea % eb; edbz = 1'b0; lat = 17;
                    end
                    rsp_cyc    = cyc + lat;
                    busy_until = cyc + lat;
                    m_last     = gk[0];
                end
            end else begin
                check("rnd_ready0_busy", req0_ready, 1'b0);
                check("rnd_ready1_busy", req1_ready, 1'b0);
                check("rnd_busy", busy, 1'b1);
            end
            if (cyc == rsp_cyc) begin
                check("rnd_rsp_valid", rsp_valid, 1'b1);
                check("rnd_id", rsp_id, eid);
                check("rnd_quotient", rsp_quotient, eq);
                check("rnd_remainder", rsp_remainder, er);
                check("rnd_dbz", rsp_div_by_zero, edbz);
                if (eb != 16'h0) begin
                    check("rnd_identity", 32'(rsp_quotient) * 32'(eb) + 32'(rsp_remainder), 32'(ea));
                    check("rnd_rem_lt_div", rsp_remainder < eb, 1'b1);
                end
                if (!mix) check("rnd_rr_seq", rsp_id, nresp % 2);
                nresp++;
            end else begin
                check("rnd_no_rsp", rsp_valid, 1'b0);
            end
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (gk == k) begin
                    v[k] = mix ? ($urandom_range(0, 1) == 1) : 1'b1;
                    a[k] = 16'($urandom);
                    b[k] = rand_div();
                end else if (!v[k]) begin
                    v[k] = mix ? ($urandom_range(0, 2) == 0) : 1'b1;
                    if (v[k]) begin
                        a[k] = 16'($urandom);
                        b[k] = rand_div();
                    end
                end
                drive(k[0], v[k], a[k], b[k]);
            end
        end
        check("rnd_all_responses", nresp, nops);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        int  t_acc;
        bit  bad;

        vecs[0] = '{id: 1'b0, a: 16'd100,   b: 16'd7,     q: 16'd14,   r: 16'd2,    dbz: 1'b0, lat: 17};
        vecs[1] = '{id: 1'b1, a: 16'd1234,  b: 16'd0,     q: 16'hFFFF, r: 16'h04D2, dbz: 1'b1, lat: 1};
        vecs[2] = '{id: 1'b0, a: 16'hFFFF,  b: 16'd1,     q: 16'hFFFF, r: 16'h0000, dbz: 1'b0, lat: 17};
        vecs[3] = '{id: 1'b1, a: 16'd5,     b: 16'd9,     q: 16'd0,    r: 16'd5,    dbz: 1'b0, lat: 17};
        vecs[4] = '{id: 1'b0, a: 16'd0,     b: 16'd3,     q: 16'd0,    r: 16'd0,    dbz: 1'b0, lat: 17};
        vecs[5] = '{id: 1'b1, a: 16'hFFFF,  b: 16'hFFFF,  q: 16'd1,    r: 16'd0,    dbz: 1'b0, lat: 17};
        vecs[6] = '{id: 1'b0, a: 16'd0,     b: 16'd0,     q: 16'hFFFF, r: 16'h0000, dbz: 1'b1, lat: 1};
        vecs[7] = '{id: 1'b1, a: 16'd1000,  b: 16'd7,     q: 16'd142,  r: 16'd6,    dbz: 1'b0, lat: 17};

        // Reset with both requesters pending: nothing may be accepted.
        reset = 1'b0;
        drive(1'b0, 1'b1, 16'd11, 16'd2);
        drive(1'b1, 1'b1, 16'd22, 16'd3);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_quotient", rsp_quotient, 16'h0);
        check("rst_remainder", rsp_remainder, 16'h0);
        check("rst_dbz", rsp_div_by_zero, 1'b0);
        check("rst_id", rsp_id, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        reset  = 1'b1;
        m_last = 1'b1;

        // Directed vectors; the first lands in the very cycle reset is released.
        for (int i = 0; i < 8; i++) begin
            apply_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                      vecs[i].dbz, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Reset pulse in the middle of an operation aborts it.
        drive(1'b0, 1'b1, 16'd1000, 16'd3);
        @(negedge clk);
        check("abort_accept", req0_ready, 1'b1);
        t_acc = cyc;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'd1000, 16'd3);
        repeat (7) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        @(posedge clk); #1;
        reset  = 1'b1;
        m_last = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_quotient_cleared", rsp_quotient, 16'h0);
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) bad = 1'b1;
        end
        check("abort_no_rsp", bad, 1'b0);
        @(posedge clk); #1;
        apply_one(1'b1, 16'd50000, 16'd123, 16'd406, 16'd62, 1'b0, 17, "post_abort");

        // Back-to-back tie after reset: strict alternation starting with req0.
        do_reset(2);
        run_pair(6, 1'b0);
        @(posedge clk); #1;

        // Mixed random valid patterns.
        run_pair(12, 1'b1);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
